// File: rtl/rv32i_types.sv
// Shared types and constants for the data-side load/store path.
//   lsu_state_t      : load/store unit FSM states
//   mdr_sel_t        : load format select codes (mdr_lw .. mdr_lbu)
//   be_byte/half/word: unshifted store byte-enable masks
//   lsu_misaligned() : alignment check for an incoming request
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    FINISH = 2'b10
  } lsu_state_t;

  typedef logic [2:0] mdr_sel_t;

  localparam mdr_sel_t mdr_lw  = 3'b000;
  localparam mdr_sel_t mdr_lh  = 3'b001;
  localparam mdr_sel_t mdr_lhu = 3'b010;
  localparam mdr_sel_t mdr_lb  = 3'b011;
  localparam mdr_sel_t mdr_lbu = 3'b100;

  localparam logic [3:0] be_byte = 4'b0001;
  localparam logic [3:0] be_half = 4'b0011;
  localparam logic [3:0] be_word = 4'b1111;

  // Loads take their access size from the load format, stores from the byte mask.
  function automatic logic lsu_misaligned(input logic     is_read,
                                          input mdr_sel_t sel,
                                          input logic [3:0] be,
                                          input logic [1:0] offset);
    logic is_half;
    logic is_word;
    is_half = is_read ? ((sel == mdr_lh) || (sel == mdr_lhu)) : (be == be_half);
    is_word = is_read ? (sel == mdr_lw) : (be == be_word);
    return (is_half && offset[0]) || (is_word && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load data extractor.
//   dmem_rdata : raw memory word
//   offset     : byte offset of the access within the word
//   mdr_sel    : load format
//   ext_data   : selected lane, sign- or zero-extended to 32 bits
//   illegal    : mdr_sel is not one of the five defined load formats
module load_extend
  import rv32i_types::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  offset,
  input  mdr_sel_t    mdr_sel,
  output logic [31:0] ext_data,
  output logic        illegal
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = dmem_rdata[{offset, 3'b000} +: 8];
    half_lane = dmem_rdata[{offset[1], 4'b0000} +: 16];
    ext_data  = '0;
    illegal   = 1'b0;
    unique case (mdr_sel)
      mdr_lw:  ext_data = dmem_rdata;
      mdr_lh:  ext_data = {{16{half_lane[15]}}, half_lane};
      mdr_lhu: ext_data = {16'h0000, half_lane};
      mdr_lb:  ext_data = {{24{byte_lane[7]}}, byte_lane};
      mdr_lbu: ext_data = {24'h000000, byte_lane};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-side load/store unit between the MEM stage and the data memory port.
// Runs one memory transaction per accepted request, lane-shifts store data and
// byte enables, extends load data, and rejects misaligned/illegal requests
// without issuing a memory strobe.
//   clk, rst (sync, active-high)
//   req_valid/req_read/req_write/mdr_sel/mem_byte_enable/addr/wdata : request
//   busy, done, err, rdata                                          : status/result
//   dmem_read/dmem_write/dmem_address/dmem_wdata/dmem_byte_enable   : memory request
//   dmem_resp/dmem_rdata                                            : memory response
module mem_access_unit
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  mdr_sel,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value in the last ACCESS cycle before a timeout fires.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  mdr_sel_t         mdr_sel_q, mdr_sel_d;
  logic [3:0]       be_q, be_d;
  logic             read_q, read_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [1:0]       offset;
  mdr_sel_t         ext_sel;
  logic [31:0]      ext_data;
  logic             ext_illegal;
  logic             req_misaligned;

  assign offset = addr_q[1:0];

  // In IDLE the extender only serves the legality check on the incoming format;
  // afterwards it works on the registered format.
  assign ext_sel = (state_q == IDLE) ? mdr_sel : mdr_sel_q;

  load_extend u_load_extend (
    .dmem_rdata (dmem_rdata),
    .offset     (offset),
    .mdr_sel    (ext_sel),
    .ext_data   (ext_data),
    .illegal    (ext_illegal)
  );

  assign req_misaligned = lsu_misaligned(req_read, mdr_sel, mem_byte_enable, addr[1:0]);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mdr_sel_d = mdr_sel_q;
    be_d      = be_q;
    read_d    = read_q;
    write_d   = write_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      IDLE: begin
        // A request with neither flag set is not a memory op and is dropped.
        if (req_valid && (req_read || req_write)) begin
          addr_d    = addr;
          wdata_d   = wdata;
          mdr_sel_d = mdr_sel;
          be_d      = mem_byte_enable;
          read_d    = req_read;
          write_d   = req_write;
          cnt_d     = '0;
          if (req_read && req_write) begin
            state_d = FINISH;
            err_d   = 1'b1;
          end else if (req_misaligned || (req_read && ext_illegal)) begin
            state_d = FINISH;
            err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            err_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the final cycle still counts as success.
        if (dmem_resp) begin
          state_d = FINISH;
          err_d   = 1'b0;
          if (read_q) begin
            rdata_d = ext_data;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          state_d = FINISH;
          err_d   = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mdr_sel_q <= mdr_lw;
      be_q      <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mdr_sel_q <= mdr_sel_d;
      be_q      <= be_d;
      read_q    <= read_d;
      write_q   <= write_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FINISH);
  assign err              = (state_q == FINISH) && err_q;
  assign rdata            = rdata_q;
  assign dmem_read        = (state_q == ACCESS) && read_q;
  assign dmem_write       = (state_q == ACCESS) && write_q;
  assign dmem_address     = {addr_q[31:2], 2'b00};
  assign dmem_wdata       = wdata_q << {offset, 3'b000};
  assign dmem_byte_enable = be_q << offset;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_read, req_write;
  logic [2:0]  mdr_sel;
  logic [3:0]  mem_byte_enable;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;

  int tests = 0;
  int fails = 0;
  logic [31:0] model_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_read         (req_read),
    .req_write        (req_write),
    .mdr_sel          (mdr_sel),
    .mem_byte_enable  (mem_byte_enable),
    .addr             (addr),
    .wdata            (wdata),
    .busy             (busy),
    .done             (done),
    .err              (err),
    .rdata            (rdata),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  sel;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;     // cycle of ACCESS in which resp is given; 0 = never
    logic [31:0] word;
    logic        early;     // rejected without a strobe
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference load extension from plain arithmetic on the memory word.
  function automatic logic [31:0] ext_model(input logic [2:0] sel, input logic [1:0] off,
                                            input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * off)) % 256;
    h = (w >> (16 * (off / 2))) % 65536;
    case (sel)
      3'd0: return w;
      3'd1: return (h >= 32768) ? (32'hFFFF0000 + h) : h;
      3'd2: return h;
      3'd3: return (b >= 128) ? (32'hFFFFFF00 + b) : b;
      default: return b;
    endcase
  endfunction

  // Fill in expectations for a request from the access rules and the current rdata.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int unsigned off;
    bit half, word, mis;
    r = v;
    off = v.addr % 4;
    half = v.rd ? (v.sel == 3'd1 || v.sel == 3'd2) : (v.be == 4'b0011);
    word = v.rd ? (v.sel == 3'd0) : (v.be == 4'b1111);
    mis = (half && (off % 2 == 1)) || (word && off != 0);
    r.early = (v.rd && v.wr) || mis || (v.rd && v.sel > 3'd4);
    r.exp_err = r.early || v.delay == 0 || v.delay > int'(TO);
    r.exp_be = 4'((v.be * (1 << off)) % 16);
    r.exp_wdata = v.wdata << (8 * off);
    if (v.rd && !v.wr && !r.exp_err) model_rdata = ext_model(v.sel, 2'(off), v.word);
    r.exp_rdata = model_rdata;
    return r;
  endfunction

  task automatic run_txn(input vec_t v, input string name);
    bit got;
    @(negedge clk);
    req_valid = 1'b1;
    req_read = v.rd;
    req_write = v.wr;
    mdr_sel = v.sel;
    mem_byte_enable = v.be;
    addr = v.addr;
    wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    if (!v.rd && !v.wr) begin
      chk({name, " ignored busy"}, 32'(busy), 0);
      chk({name, " ignored done"}, 32'(done), 0);
      return;
    end
    if (v.early) begin
      chk({name, " early done"}, 32'(done), 1);
      chk({name, " early err"}, 32'(err), 1);
      chk({name, " early strobe"}, 32'(dmem_read | dmem_write), 0);
      chk({name, " early rdata"}, rdata, v.exp_rdata);
      return;
    end
    got = 0;
    for (int k = 1; k <= int'(TO); k++) begin
      if (!got) begin
        if (k > 1) @(negedge clk);
        chk({name, " dmem_read"}, 32'(dmem_read), 32'(v.rd));
        chk({name, " dmem_write"}, 32'(dmem_write), 32'(v.wr));
        chk({name, " busy"}, 32'(busy), 1);
        chk({name, " no early done"}, 32'(done), 0);
        chk({name, " address"}, dmem_address, {v.addr[31:2], 2'b00});
        if (v.wr) begin
          chk({name, " byte_enable"}, 32'(dmem_byte_enable), 32'(v.exp_be));
          chk({name, " dmem_wdata"}, dmem_wdata, v.exp_wdata);
        end
        if (k == v.delay) begin
          dmem_resp = 1'b1;
          dmem_rdata = v.word;
          got = 1;
        end
      end
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    dmem_rdata = $urandom;
    chk({name, " done"}, 32'(done), 1);
    chk({name, " err"}, 32'(err), 32'(v.exp_err));
    chk({name, " strobe low"}, 32'(dmem_read | dmem_write), 0);
    chk({name, " rdata"}, rdata, v.exp_rdata);
  endtask

  vec_t tbl[16];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int consec, strobes, dones;
    bit prev, s;
    vec_t v;
    logic [3:0] bes[3];

    // rd wr sel be addr wdata delay word early err rdata be wdata
    tbl[0]  = '{1, 0, 3'd3, 4'h1, 32'h1003, 32'h0, 3, 32'h80FFFF00, 0, 0, 32'hFFFFFF80, 4'h0, 32'h0};
    tbl[1]  = '{1, 0, 3'd2, 4'h1, 32'h2002, 32'h0, 1, 32'hBEEF1234, 0, 0, 32'h0000BEEF, 4'h0, 32'h0};
    tbl[2]  = '{1, 0, 3'd1, 4'h1, 32'h2002, 32'h0, 1, 32'hBEEF1234, 0, 0, 32'hFFFFBEEF, 4'h0, 32'h0};
    tbl[3]  = '{0, 1, 3'd3, 4'h1, 32'h3001, 32'hAB, 2, 32'h0, 0, 0, 32'hFFFFBEEF, 4'h2, 32'h0000AB00};
    tbl[4]  = '{1, 0, 3'd0, 4'h1, 32'h4002, 32'h0, 1, 32'h0, 1, 1, 32'hFFFFBEEF, 4'h0, 32'h0};
    tbl[5]  = '{1, 0, 3'd0, 4'h1, 32'h5000, 32'h0, 1, 32'h12345678, 0, 0, 32'h12345678, 4'h0, 32'h0};
    tbl[6]  = '{1, 0, 3'd4, 4'h1, 32'h5001, 32'h0, 2, 32'h00009A00, 0, 0, 32'h0000009A, 4'h0, 32'h0};
    tbl[7]  = '{0, 1, 3'd3, 4'h3, 32'h6002, 32'hCAFE, 1, 32'h0, 0, 0, 32'h9A, 4'hC, 32'hCAFE0000};
    tbl[8]  = '{0, 1, 3'd3, 4'h3, 32'h6001, 32'hCAFE, 1, 32'h0, 1, 1, 32'h9A, 4'h0, 32'h0};
    tbl[9]  = '{1, 0, 3'd5, 4'h1, 32'h7000, 32'h0, 1, 32'h0, 1, 1, 32'h9A, 4'h0, 32'h0};
    tbl[10] = '{1, 1, 3'd0, 4'hF, 32'h7004, 32'h0, 1, 32'h0, 1, 1, 32'h9A, 4'h0, 32'h0};
    tbl[11] = '{0, 1, 3'd3, 4'hF, 32'h8000, 32'hDEADBEEF, 4, 32'h0, 0, 0, 32'h9A, 4'hF, 32'hDEADBEEF};
    tbl[12] = '{1, 0, 3'd3, 4'h1, 32'h9000, 32'h0, 0, 32'h0, 0, 1, 32'h9A, 4'h0, 32'h0};
    tbl[13] = '{1, 0, 3'd0, 4'h1, 32'hB000, 32'h0, 1, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 4'h0, 32'h0};
    tbl[14] = '{0, 0, 3'd0, 4'h1, 32'hC000, 32'h0, 1, 32'h0, 0, 0, 32'hCAFEF00D, 4'h0, 32'h0};
    tbl[15] = '{1, 0, 3'd1, 4'h1, 32'hA003, 32'h0, 1, 32'h0, 1, 1, 32'hCAFEF00D, 4'h0, 32'h0};

    rst = 1'b1;
    req_valid = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
    mdr_sel = 3'd0;
    mem_byte_enable = 4'h0;
    addr = 32'h0;
    wdata = 32'h0;
    dmem_resp = 1'b0;
    dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset err", 32'(err), 0);
    chk("reset strobes", 32'({dmem_read, dmem_write}), 0);
    chk("reset rdata", rdata, 0);
    chk("reset address", dmem_address, 0);
    chk("reset wdata", dmem_wdata, 0);
    chk("reset byte_enable", 32'(dmem_byte_enable), 0);

    for (int i = 0; i < 16; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset while a load is waiting for memory; a late response must be ignored.
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    mdr_sel = 3'd0; addr = 32'h100;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midreset strobe before", 32'(dmem_read), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset strobe after", 32'(dmem_read), 0);
    chk("midreset busy", 32'(busy), 0);
    chk("midreset rdata", rdata, 0);
    dmem_resp = 1'b1;
    dmem_rdata = 32'h55AA55AA;
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (done) dones++;
    end
    chk("midreset no done", 32'(dones), 0);
    model_rdata = 32'h0;

    // req_valid held high with memory always responding: one access per done.
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    mdr_sel = 3'd0; addr = 32'h40;
    dmem_resp = 1'b1;
    dmem_rdata = 32'h0BADF00D;
    consec = 0; strobes = 0; dones = 0; prev = 0;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (c == 29) req_valid = 1'b0;
      s = dmem_read | dmem_write;
      if (s && prev) consec++;
      if (s) strobes++;
      if (done) dones++;
      prev = s;
    end
    dmem_resp = 1'b0;
    chk("held no back-to-back strobe", 32'(consec), 0);
    chk("held strobes per done", 32'(strobes), 32'(dones));
    chk("held progress", 32'(dones >= 5), 1);
    chk("held idle at end", 32'(busy), 0);
    chk("held rdata", rdata, 32'h0BADF00D);
    model_rdata = 32'h0BADF00D;

    bes[0] = 4'b0001; bes[1] = 4'b0011; bes[2] = 4'b1111;
    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      v.rd = (r == 0) || (r >= 2 && r < 11);
      v.wr = (r == 0) || (r >= 11);
      v.addr = $urandom;
      v.wdata = $urandom;
      v.word = $urandom;
      v.delay = $urandom_range(0, 5);
      // Keep the field that does not apply to this direction at a value that never misaligns.
      v.sel = v.rd ? 3'($urandom_range(0, 7)) : 3'd3;
      v.be = v.wr ? bes[$urandom_range(0, 2)] : 4'b0001;
      v = model(v);
      run_txn(v, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
